display_reader: RTL and testbench
=================================

DISPLAY_READER -- requirements
Module: display_reader

Interface
REQ-001 Parameter WIDTH, default 320: active pixels per line.
REQ-002 Parameter HEIGHT, default 240: active lines per frame.
REQ-003 Parameters H_FRONT/H_SYNC/H_BACK, defaults 8/48/40: horizontal blanking widths in pixels.
REQ-004 Parameters V_FRONT/V_SYNC/V_BACK, defaults 2/2/6: vertical blanking widths in lines.
REQ-005 Parameter PREFILL, default 64: read-FIFO words required before scan-out starts.
REQ-006 Ports SHALL be exactly the following:
- vpg_pclk  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- iFrameEn  in  1  level; request continuous scan-out.
- Read_DATA  in  32  read-FIFO data, valid the cycle after a pop.
- read_empty_rdfifo  in  1  read FIFO empty.
- read_fifo_rdusedw  in  9  read-FIFO fill level.
- read_init  out  1  one-cycle pulse; restart frame-buffer read address.
- oRead  out  1  read-FIFO pop request.
- oData  out  32  pixel; 0 outside active area or on underflow.
- oDE  out  1  data enable, aligned with oData.
- oHS  out  1  horizontal sync, active low, aligned with oData.
- oVS  out  1  vertical sync, active low, aligned with oData.
- oUnderflow  out  1  sticky underflow flag, current frame.
- oUfCount  out  16  underflow event counter (see Configuration).

Function
REQ-007 States: IDLE, INIT, PREFILL, RUN.
REQ-008 IDLE: counters held 0, oRead=0; on iFrameEn=1 go to INIT.
REQ-009 INIT: read_init=1 for exactly one cycle, then PREFILL.
REQ-010 PREFILL: wait until read_fifo_rdusedw >= PREFILL, then RUN with hcnt=0, vcnt=0.
REQ-011 RUN: hcnt counts 0..H_TOTAL-1 (H_TOTAL=WIDTH+H_FRONT+H_SYNC+H_BACK); on wrap vcnt increments 0..V_TOTAL-1, likewise.
REQ-012 Order per line/frame: active, front porch, sync, back porch; HS low when WIDTH+H_FRONT <= hcnt < WIDTH+H_FRONT+H_SYNC; VS analogous on vcnt.
REQ-013 Active when hcnt<WIDTH and vcnt<HEIGHT; oRead = active AND NOT read_empty_rdfifo.
REQ-014 Latency: oDE/oHS/oVS/oData SHALL be registered one cycle after the counter state that generates them, so oData = Read_DATA popped the previous cycle.
REQ-015 Underflow: active and read_empty_rdfifo=1 -> no pop; oData=0 with oDE=1 next cycle; oUnderflow set.
REQ-016 oUnderflow cleared on the cycle hcnt=0,vcnt=0 of each new frame in RUN.
REQ-017 Frame wrap (hcnt=H_TOTAL-1, vcnt=V_TOTAL-1): if iFrameEn=1, pulse read_init and continue RUN without prefill; else go to IDLE.
REQ-018 iFrameEn deasserted mid-frame SHALL NOT truncate the frame.
REQ-019 Counter widths SHALL hold H_TOTAL-1 and V_TOTAL-1 with no overflow; comparisons are unsigned.
REQ-020 Outside RUN: oDE=0, oHS=1, oVS=1, oData=0, oRead=0.

Reset
REQ-021 reset_n=0 asynchronously forces IDLE, counters 0, read_init=0, oRead=0, oData=0, oDE=0, oHS=1, oVS=1, oUnderflow=0, oUfCount=0.
REQ-022 Reset asserted in any state, including mid-line in RUN, SHALL abort immediately; after release, restart from IDLE only.

Configuration
REQ-023 Macro DISPLAY_READER_UFCNT_EN defined: oUfCount increments by 1 per underflowed pixel, saturates at 16'hFFFF, cleared only by reset.
REQ-024 Macro undefined: oUfCount tied to 0, no counter logic; all other behaviour identical.

Verification
REQ-025 Reset then iFrameEn=1, rdusedw held 10 -> one read_init pulse, stays PREFILL, oRead=0, oDE=0.
REQ-026 rdusedw rises to 64, FIFO never empty -> exactly 320 oDE cycles per line, 240 lines per frame, oData equals FIFO sequence 1,2,3... with one-cycle latency.
REQ-027 Full frame -> HS low 48 cycles starting hcnt 328; VS low 2 lines starting vcnt 242; H_TOTAL 416, V_TOTAL 250.
REQ-028 Force empty for 5 active pixels -> 5 oData=0 with oDE=1, oUnderflow=1 until next frame start, oUfCount=5 with macro, 0 without.
REQ-029 Drop iFrameEn at line 100 -> frame completes to vcnt 249, no read_init, returns IDLE.
REQ-030 reset_n low at hcnt 150 in RUN -> all outputs at reset values same cycle, no further oRead.

Source files
------------

// File: rtl/display_reader.sv
// Scan-out timing generator that pops pixels from a frame-buffer read FIFO.
// Define DISPLAY_READER_UFCNT_EN to build the saturating underflow event counter.
module display_reader #(
  parameter int WIDTH   = 320,
  parameter int HEIGHT  = 240,
  parameter int H_FRONT = 8,
  parameter int H_SYNC  = 48,
  parameter int H_BACK  = 40,
  parameter int V_FRONT = 2,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 6,
  parameter int PREFILL = 64
) (
  input  logic        vpg_pclk,
  input  logic        reset_n,
  input  logic        iFrameEn,
  input  logic [31:0] Read_DATA,
  input  logic        read_empty_rdfifo,
  input  logic [8:0]  read_fifo_rdusedw,
  output logic        read_init,
  output logic        oRead,
  output logic [31:0] oData,
  output logic        oDE,
  output logic        oHS,
  output logic        oVS,
  output logic        oUnderflow,
  output logic [15:0] oUfCount
);

  localparam int H_TOTAL = WIDTH + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = HEIGHT + V_FRONT + V_SYNC + V_BACK;
  // One extra code point so the sync-end bound never aliases to zero.
  localparam int HW = (H_TOTAL > 1) ? $clog2(H_TOTAL + 1) : 1;
  localparam int VW = (V_TOTAL > 1) ? $clog2(V_TOTAL + 1) : 1;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(WIDTH);
  localparam logic [HW-1:0] HS_BEG = HW'(WIDTH + H_FRONT);
  localparam logic [HW-1:0] HS_END = HW'(WIDTH + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(HEIGHT);
  localparam logic [VW-1:0] VS_BEG = VW'(HEIGHT + V_FRONT);
  localparam logic [VW-1:0] VS_END = VW'(HEIGHT + V_FRONT + V_SYNC);
  localparam logic [8:0]    PREFILL_LVL = 9'(PREFILL);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_INIT,
    ST_PREFILL,
    ST_RUN
  } state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic          de_q, de_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          uf_q, uf_d;
  logic          underflow_q, underflow_d;

  logic running;
  logic active;
  logic uf_pix;
  logic frame_start;

  assign running     = (state_q == ST_RUN);
  assign active      = running && (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
  assign uf_pix      = active && read_empty_rdfifo;
  assign frame_start = running && (hcnt_q == '0) && (vcnt_q == '0);

  always_ff @(posedge vpg_pclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      de_q        <= 1'b0;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      uf_q        <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hcnt_q      <= hcnt_d;
      vcnt_q      <= vcnt_d;
      de_q        <= de_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      uf_q        <= uf_d;
      underflow_q <= underflow_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hcnt_d    = hcnt_q;
    vcnt_d    = vcnt_q;
    read_init = 1'b0;
    oRead     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        hcnt_d = '0;
        vcnt_d = '0;
        if (iFrameEn) state_d = ST_INIT;
      end
      ST_INIT: begin
        read_init = 1'b1;
        state_d   = ST_PREFILL;
      end
      ST_PREFILL: begin
        hcnt_d = '0;
        vcnt_d = '0;
        if (read_fifo_rdusedw >= PREFILL_LVL) state_d = ST_RUN;
      end
      ST_RUN: begin
        oRead = active && !read_empty_rdfifo;
        if (hcnt_q == H_LAST) begin
          hcnt_d = '0;
          if (vcnt_q == V_LAST) begin
            vcnt_d = '0;
            // Back-to-back frames skip prefill; the FIFO is already primed.
            if (iFrameEn) read_init = 1'b1;
            else          state_d   = ST_IDLE;
          end else begin
            vcnt_d = vcnt_q + 1'b1;
          end
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    de_d        = active;
    hs_d        = !(running && (hcnt_q >= HS_BEG) && (hcnt_q < HS_END));
    vs_d        = !(running && (vcnt_q >= VS_BEG) && (vcnt_q < VS_END));
    uf_d        = uf_pix;
    underflow_d = (frame_start ? 1'b0 : underflow_q) | uf_pix;
  end

  // FIFO data arrives the cycle after the pop, so it lines up with the registered timing.
  assign oData      = (de_q && !uf_q) ? Read_DATA : 32'h0000_0000;
  assign oDE        = de_q;
  assign oHS        = hs_q;
  assign oVS        = vs_q;
  assign oUnderflow = underflow_q;

`ifdef DISPLAY_READER_UFCNT_EN
  logic [15:0] ufcnt_q;

  always_ff @(posedge vpg_pclk or negedge reset_n) begin
    if (!reset_n) begin
      ufcnt_q <= '0;
    end else if (uf_pix && (ufcnt_q != 16'hFFFF)) begin
      ufcnt_q <= ufcnt_q + 16'd1;
    end
  end

  assign oUfCount = ufcnt_q;
`else
  assign oUfCount = 16'h0000;
`endif

endmodule

// File: tb/tb_display_reader.sv
// Directed bench for display_reader: a small-geometry instance for full-frame behaviour
// plus a default-parameter instance for one-line timing.
module tb_display_reader;

  // Small geometry: H_TOTAL = 8+2+3+2 = 15, V_TOTAL = 4+1+2+1 = 8, 120 cycles per frame.
  localparam int SW    = 8;
  localparam int SH    = 4;
  localparam int S_HT  = 15;
  localparam int S_VT  = 8;
  localparam int FRAME = 120;
  localparam int UF_FIRST = 137;   // frame 1, line 1, pixel 2
  localparam int UF_LAST  = 141;   // frame 1, line 1, pixel 6
  localparam int DROP_T   = 270;   // frame 2, line 2, pixel 0
  localparam int END_T    = 360;   // first counter slot after frame 2

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frameEn;
  logic        empty;
  logic [31:0] rdData;
  logic [8:0]  usedw;

  logic        readInit, oRead, oDE, oHS, oVS, oUnderflow;
  logic [31:0] oData;
  logic [15:0] oUfCount;

  logic        dReadInit, dRead, dDE, dHS, dVS, dUnderflow;
  logic [31:0] dData;
  logic [15:0] dUfCount;

  int checks = 0;
  int errors = 0;
  int expSeq = 1;
  int fifoSeq = 1;
  logic pop;

  logic        eDE, eHS, eVS, eRead, eInit, eUf;
  logic [31:0] eData;

  always #5 clk = ~clk;

  display_reader #(
    .WIDTH(SW), .HEIGHT(SH), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .PREFILL(16)
  ) dut (
    .vpg_pclk(clk), .reset_n(rst_n), .iFrameEn(frameEn), .Read_DATA(rdData),
    .read_empty_rdfifo(empty), .read_fifo_rdusedw(usedw), .read_init(readInit),
    .oRead(oRead), .oData(oData), .oDE(oDE), .oHS(oHS), .oVS(oVS),
    .oUnderflow(oUnderflow), .oUfCount(oUfCount)
  );

  display_reader dflt (
    .vpg_pclk(clk), .reset_n(rst_n), .iFrameEn(frameEn), .Read_DATA(rdData),
    .read_empty_rdfifo(empty), .read_fifo_rdusedw(usedw), .read_init(dReadInit),
    .oRead(dRead), .oData(dData), .oDE(dDE), .oHS(dHS), .oVS(dVS),
    .oUnderflow(dUnderflow), .oUfCount(dUfCount)
  );

  // FIFO with registered output: a pop seen before the edge presents the next word after it.
  initial begin
    rdData = 32'h0;
    forever begin
      @(negedge clk);
      #2;
      pop = oRead;
      @(posedge clk);
      #1;
      if (pop) begin
        rdData = fifoSeq;
        fifoSeq++;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic bit pixActive(int t);
    return (t < END_T) && ((t % S_HT) < SW) && (((t / S_HT) % S_VT) < SH);
  endfunction

  function automatic bit hsLow(int t);
    return (t < END_T) && ((t % S_HT) >= 10) && ((t % S_HT) < 13);
  endfunction

  function automatic bit vsLow(int t);
    return (t < END_T) && (((t / S_HT) % S_VT) >= 5) && (((t / S_HT) % S_VT) < 7);
  endfunction

  function automatic bit isUf(int t);
    return (t >= UF_FIRST) && (t <= UF_LAST);
  endfunction

  function automatic bit enAt(int t);
    return t < DROP_T;
  endfunction

  // Moves to the sample of counter slot k (the DUT is then in slot k+1) and
  // builds the expected values for that sample.
  task automatic applyStimulus(input int k);
    @(negedge clk);
    empty   = isUf(k + 1);
    frameEn = enAt(k + 1);
    #1;
    eDE = pixActive(k);
    eHS = !hsLow(k);
    eVS = !vsLow(k);
    if (eDE && !isUf(k)) begin
      eData = expSeq;
      expSeq++;
    end else begin
      eData = 32'h0;
    end
    eRead = pixActive(k + 1) && !isUf(k + 1);
    eInit = ((k + 1) < END_T) && (((k + 1) % FRAME) == FRAME - 1) && enAt(k + 1);
    eUf   = (k >= UF_FIRST) && (k < 2 * FRAME);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; frameEn = 1'b0; empty = 1'b0; usedw = 9'd0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (oDE !== 1'b0) begin errors++; $display("[TB] FAIL reset_de got %0b want 0", oDE); end
    checks++; if (oHS !== 1'b1 || oVS !== 1'b1) begin errors++; $display("[TB] FAIL reset_sync got %0b%0b want 11", oHS, oVS); end
    checks++; if (oData !== 32'h0) begin errors++; $display("[TB] FAIL reset_data got %h want 0", oData); end
    checks++; if (oRead !== 1'b0 || readInit !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd got %0b%0b want 00", oRead, readInit); end
    checks++; if (oUnderflow !== 1'b0 || oUfCount !== 16'h0) begin errors++; $display("[TB] FAIL reset_uf got %0b/%0d want 0/0", oUnderflow, oUfCount); end
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (oDE !== 1'b0 || oRead !== 1'b0 || readInit !== 1'b0) begin errors++; $display("[TB] FAIL idle_after_reset got %0b%0b%0b want 000", oDE, oRead, readInit); end
  endtask

  task automatic test_prefill();
    int initCnt = 0;
    frameEn = 1'b1;
    usedw   = 9'd10;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (readInit) initCnt++;
      checks++; if (oRead !== 1'b0 || oDE !== 1'b0) begin errors++; $display("[TB] FAIL prefill_idle i=%0d got rd=%0b de=%0b want 0 0", i, oRead, oDE); end
    end
    checks++; if (initCnt !== 1) begin errors++; $display("[TB] FAIL prefill_init_pulses got %0d want 1", initCnt); end
  endtask

  task automatic test_frame();
    int deCnt = 0, hsCnt = 0, vsCnt = 0, initCnt = 0;
    usedw = 9'd64;
    @(negedge clk);
    for (int k = 0; k < FRAME; k++) begin
      applyStimulus(k);
      if (oDE) deCnt++;
      if (!oHS) hsCnt++;
      if (!oVS) vsCnt++;
      if (readInit) initCnt++;
      checks++; if (oDE !== eDE) begin errors++; $display("[TB] FAIL frame_de k=%0d got %0b want %0b", k, oDE, eDE); end
      checks++; if (oHS !== eHS) begin errors++; $display("[TB] FAIL frame_hs k=%0d got %0b want %0b", k, oHS, eHS); end
      checks++; if (oVS !== eVS) begin errors++; $display("[TB] FAIL frame_vs k=%0d got %0b want %0b", k, oVS, eVS); end
      checks++; if (oData !== eData) begin errors++; $display("[TB] FAIL frame_data k=%0d got %0d want %0d", k, oData, eData); end
      checks++; if (oRead !== eRead) begin errors++; $display("[TB] FAIL frame_rd k=%0d got %0b want %0b", k, oRead, eRead); end
      checks++; if (readInit !== eInit) begin errors++; $display("[TB] FAIL frame_init k=%0d got %0b want %0b", k, readInit, eInit); end
      checks++; if (oUnderflow !== eUf) begin errors++; $display("[TB] FAIL frame_uf k=%0d got %0b want %0b", k, oUnderflow, eUf); end
    end
    checks++; if (deCnt !== SW * SH) begin errors++; $display("[TB] FAIL frame_de_total got %0d want %0d", deCnt, SW * SH); end
    checks++; if (hsCnt !== 3 * S_VT) begin errors++; $display("[TB] FAIL frame_hs_total got %0d want %0d", hsCnt, 3 * S_VT); end
    checks++; if (vsCnt !== 2 * S_HT) begin errors++; $display("[TB] FAIL frame_vs_total got %0d want %0d", vsCnt, 2 * S_HT); end
    checks++; if (initCnt !== 1) begin errors++; $display("[TB] FAIL frame_init_total got %0d want 1", initCnt); end
  endtask

  task automatic test_underflow();
    int zeroCnt = 0;
    logic [15:0] expCount;
`ifdef DISPLAY_READER_UFCNT_EN
    expCount = 16'd5;
`else
    expCount = 16'd0;
`endif
    for (int k = FRAME; k <= 2 * FRAME; k++) begin
      applyStimulus(k);
      if (oDE && oData == 32'h0) zeroCnt++;
      checks++; if (oDE !== eDE) begin errors++; $display("[TB] FAIL uf_de k=%0d got %0b want %0b", k, oDE, eDE); end
      checks++; if (oData !== eData) begin errors++; $display("[TB] FAIL uf_data k=%0d got %0d want %0d", k, oData, eData); end
      checks++; if (oRead !== eRead) begin errors++; $display("[TB] FAIL uf_rd k=%0d got %0b want %0b", k, oRead, eRead); end
      checks++; if (oUnderflow !== eUf) begin errors++; $display("[TB] FAIL uf_flag k=%0d got %0b want %0b", k, oUnderflow, eUf); end
    end
    checks++; if (zeroCnt !== 5) begin errors++; $display("[TB] FAIL uf_zero_pixels got %0d want 5", zeroCnt); end
    checks++; if (oUfCount !== expCount) begin errors++; $display("[TB] FAIL uf_count got %0d want %0d", oUfCount, expCount); end
  endtask

  task automatic test_drop_enable();
    int initCnt = 0;
    for (int k = 2 * FRAME + 1; k < END_T + 6; k++) begin
      applyStimulus(k);
      if (readInit) initCnt++;
      checks++; if (oDE !== eDE) begin errors++; $display("[TB] FAIL drop_de k=%0d got %0b want %0b", k, oDE, eDE); end
      checks++; if (oHS !== eHS) begin errors++; $display("[TB] FAIL drop_hs k=%0d got %0b want %0b", k, oHS, eHS); end
      checks++; if (oVS !== eVS) begin errors++; $display("[TB] FAIL drop_vs k=%0d got %0b want %0b", k, oVS, eVS); end
      checks++; if (oData !== eData) begin errors++; $display("[TB] FAIL drop_data k=%0d got %0d want %0d", k, oData, eData); end
      checks++; if (oRead !== eRead) begin errors++; $display("[TB] FAIL drop_rd k=%0d got %0b want %0b", k, oRead, eRead); end
    end
    checks++; if (initCnt !== 0) begin errors++; $display("[TB] FAIL drop_init_pulses got %0d want 0", initCnt); end
  endtask

  task automatic test_reset_mid_run();
    bit seen = 0;
    frameEn = 1'b1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (oDE) seen = 1;
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL restart_de got %0b want 1", seen); end
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (oDE !== 1'b0 || oData !== 32'h0) begin errors++; $display("[TB] FAIL abort_de_data got %0b/%h want 0/0", oDE, oData); end
    checks++; if (oHS !== 1'b1 || oVS !== 1'b1) begin errors++; $display("[TB] FAIL abort_sync got %0b%0b want 11", oHS, oVS); end
    checks++; if (oRead !== 1'b0 || readInit !== 1'b0) begin errors++; $display("[TB] FAIL abort_rd got %0b%0b want 00", oRead, readInit); end
    checks++; if (oUnderflow !== 1'b0 || oUfCount !== 16'h0) begin errors++; $display("[TB] FAIL abort_uf got %0b/%0d want 0/0", oUnderflow, oUfCount); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checks++; if (oRead !== 1'b0 || oDE !== 1'b0) begin errors++; $display("[TB] FAIL abort_hold i=%0d got rd=%0b de=%0b want 0 0", i, oRead, oDE); end
    end
    rst_n = 1'b1;
    #1;
    checks++; if (readInit !== 1'b0 || oRead !== 1'b0) begin errors++; $display("[TB] FAIL release_idle got %0b%0b want 00", readInit, oRead); end
    @(negedge clk);
    #1;
    checks++; if (readInit !== 1'b1) begin errors++; $display("[TB] FAIL release_init got %0b want 1", readInit); end
  endtask

  task automatic test_default_line();
    bit seen = 0;
    int deCnt = 0, hsCnt = 0, hsFirst = -1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (dDE) seen = 1;
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL dflt_start got %0b want 1", seen); end
    for (int k = 0; k <= 416; k++) begin
      if (k > 0) begin
        @(negedge clk);
        #1;
      end
      if (k < 416) begin
        if (dDE) deCnt++;
        if (!dHS) begin
          hsCnt++;
          if (hsFirst < 0) hsFirst = k;
        end
      end
      checks++; if (dDE !== ((k % 416) < 320)) begin errors++; $display("[TB] FAIL dflt_de k=%0d got %0b want %0b", k, dDE, ((k % 416) < 320)); end
      checks++; if (dHS !== !(k >= 328 && k < 376)) begin errors++; $display("[TB] FAIL dflt_hs k=%0d got %0b want %0b", k, dHS, !(k >= 328 && k < 376)); end
      checks++; if (dVS !== 1'b1) begin errors++; $display("[TB] FAIL dflt_vs k=%0d got %0b want 1", k, dVS); end
    end
    checks++; if (deCnt !== 320) begin errors++; $display("[TB] FAIL dflt_de_total got %0d want 320", deCnt); end
    checks++; if (hsCnt !== 48) begin errors++; $display("[TB] FAIL dflt_hs_total got %0d want 48", hsCnt); end
    checks++; if (hsFirst !== 328) begin errors++; $display("[TB] FAIL dflt_hs_start got %0d want 328", hsFirst); end
  endtask

  initial begin
    $display("[TB] display_reader bench start");
    test_reset();
    test_prefill();
    test_frame();
    test_underflow();
    test_drop_enable();
    test_reset_mid_run();
    test_default_line();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
